// File: rtl/shift_deserializer.sv
// Serial-to-parallel receiver with a one-entry valid/ready output buffer; optional even parity via SHIFT_DESERIALIZER_PARITY_EN.
// Latency: word_o/valid_o update on the edge sampling the final frame bit; a stalled buffer drops the new word and sets sticky overrun_o.
module shift_deserializer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             serial_i,
   input  logic             bit_valid_i,
   input  logic             start_i,
   input  logic             dir_i,
   input  logic             ready_i,
   input  logic             clr_ovr_i,
   output logic [WIDTH-1:0] word_o,
   output logic             valid_o,
   output logic             busy_o,
   output logic             overrun_o,
   output logic             parity_err_o
);

`ifdef SHIFT_DESERIALIZER_PARITY_EN
   localparam int FRAME_BITS = WIDTH + 1;
`else
   localparam int FRAME_BITS = WIDTH;
`endif
   localparam int CNT_W = $clog2(FRAME_BITS + 1);
   localparam logic [CNT_W-1:0] DATA_BITS = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(FRAME_BITS - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             dir_q, dir_d;
   logic             word_done;
   logic [WIDTH-1:0] done_word;
   logic             ovr_evt;
`ifdef SHIFT_DESERIALIZER_PARITY_EN
   logic             par_q, par_d;
   logic             done_perr;
   logic             perr_q;
`endif

   // dir=0: MSB first, new bit enters bit 0; dir=1: LSB first, new bit enters the top
   function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur,
                                                 input logic dir, input logic b);
      return dir ? {b, cur[WIDTH-1:1]} : {cur[WIDTH-2:0], b};
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         shreg_q <= '0;
         cnt_q   <= '0;
         dir_q   <= 1'b0;
`ifdef SHIFT_DESERIALIZER_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
         dir_q   <= dir_d;
`ifdef SHIFT_DESERIALIZER_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      cnt_d     = cnt_q;
      dir_d     = dir_q;
      word_done = 1'b0;
      done_word = shreg_q;
`ifdef SHIFT_DESERIALIZER_PARITY_EN
      par_d     = par_q;
      done_perr = 1'b0;
`endif
      if (bit_valid_i) begin
         if (start_i) begin
            // A start bit always opens a fresh word, discarding any partial one
            state_d = SHIFT;
            dir_d   = dir_i;
            shreg_d = shift_in('0, dir_i, serial_i);
            cnt_d   = CNT_W'(1);
`ifdef SHIFT_DESERIALIZER_PARITY_EN
            par_d   = serial_i;
`endif
         end else if (state_q == SHIFT) begin
            if (cnt_q < DATA_BITS) begin
               shreg_d = shift_in(shreg_q, dir_q, serial_i);
`ifdef SHIFT_DESERIALIZER_PARITY_EN
               par_d   = par_q ^ serial_i;
`endif
            end
            if (cnt_q == LAST_BIT) begin
               word_done = 1'b1;
               state_d   = IDLE;
               cnt_d     = '0;
`ifdef SHIFT_DESERIALIZER_PARITY_EN
               done_word = shreg_q;
               done_perr = par_q ^ serial_i;
`else
               done_word = shreg_d;
`endif
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
      end
   end

   assign ovr_evt = word_done && valid_o && !ready_i;
   assign busy_o  = (state_q == SHIFT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         word_o    <= '0;
         valid_o   <= 1'b0;
         overrun_o <= 1'b0;
`ifdef SHIFT_DESERIALIZER_PARITY_EN
         perr_q    <= 1'b0;
`endif
      end else begin
         if (word_done && (!valid_o || ready_i)) begin
            word_o  <= done_word;
            valid_o <= 1'b1;
`ifdef SHIFT_DESERIALIZER_PARITY_EN
            perr_q  <= done_perr;
`endif
         end else if (valid_o && ready_i) begin
            valid_o <= 1'b0;
`ifdef SHIFT_DESERIALIZER_PARITY_EN
            perr_q  <= 1'b0;
`endif
         end
         // a new drop outranks a simultaneous clear
         if (ovr_evt) begin
            overrun_o <= 1'b1;
         end else if (clr_ovr_i) begin
            overrun_o <= 1'b0;
         end
      end
   end

`ifdef SHIFT_DESERIALIZER_PARITY_EN
   assign parity_err_o = perr_q;
`else
   assign parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_shift_deserializer.sv
// Directed plus randomized frames against a bit-list reference model of the receiver.
module tb_shift_deserializer;
   localparam int W = 8;
`ifdef SHIFT_DESERIALIZER_PARITY_EN
   localparam int FRAME = W + 1;
`else
   localparam int FRAME = W;
`endif

   logic         clk, rst, serial_i, bit_valid_i, start_i, dir_i, ready_i, clr_ovr_i;
   logic [W-1:0] word_o;
   logic         valid_o, busy_o, overrun_o, parity_err_o;

   int checks = 0;
   int failures = 0;

   // reference model state: bits collected since the last start
   bit           m_busy;
   bit           m_bits[$];
   bit           m_dir;
   logic [W-1:0] m_word;
   bit           m_valid, m_ovr, m_perr;

   shift_deserializer #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .serial_i(serial_i), .bit_valid_i(bit_valid_i),
      .start_i(start_i), .dir_i(dir_i), .ready_i(ready_i), .clr_ovr_i(clr_ovr_i),
      .word_o(word_o), .valid_o(valid_o), .busy_o(busy_o), .overrun_o(overrun_o),
      .parity_err_o(parity_err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic compare_all();
      check("word_o", 32'(word_o), 32'(m_word));
      check("valid_o", 32'(valid_o), 32'(m_valid));
      check("busy_o", 32'(busy_o), 32'(m_busy));
      check("overrun_o", 32'(overrun_o), 32'(m_ovr));
      check("parity_err_o", 32'(parity_err_o), 32'(m_perr));
   endtask

   task automatic model_reset();
      m_busy = 0; m_bits.delete(); m_dir = 0;
      m_word = '0; m_valid = 0; m_ovr = 0; m_perr = 0;
   endtask

   task automatic model_step(input bit bv, input bit st, input bit sd, input bit dr,
                             input bit rdy, input bit clr);
      bit           done = 0;
      bit           perr = 0;
      bit           ovr_evt = 0;
      logic [W-1:0] w = '0;
      if (bv) begin
         if (st) begin
            m_bits.delete(); m_dir = dr; m_busy = 1; m_bits.push_back(sd);
         end else if (m_busy) begin
            m_bits.push_back(sd);
         end
         if (m_busy && m_bits.size() == FRAME) begin
            done = 1;
            for (int k = 0; k < W; k++) begin
               if (m_dir) w[k] = m_bits[k];
               else       w[W-1-k] = m_bits[k];
            end
`ifdef SHIFT_DESERIALIZER_PARITY_EN
            for (int k = 0; k < FRAME; k++) perr ^= m_bits[k];
`endif
            m_bits.delete(); m_busy = 0;
         end
      end
      if (done) begin
         if (!m_valid || rdy) begin
            m_word = w; m_valid = 1; m_perr = perr;
         end else begin
            ovr_evt = 1;
         end
      end else if (m_valid && rdy) begin
         m_valid = 0; m_perr = 0;
      end
      if (ovr_evt) m_ovr = 1;
      else if (clr) m_ovr = 0;
   endtask

   task automatic cycle(input bit bv, input bit st, input bit sd, input bit dr,
                        input bit rdy, input bit clr);
      bit_valid_i = bv; start_i = st; serial_i = sd; dir_i = dr;
      ready_i = rdy; clr_ovr_i = clr;
      @(posedge clk);
      model_step(bv, st, sd, dr, rdy, clr);
      #1;
      compare_all();
   endtask

   // rmode: 0 = ready low, 1 = ready high, 2 = random ready/clear and start glitches
   task automatic send_bits(input logic [W-1:0] w, input bit dir, input int nbits,
                            input int gap, input int rmode, input bit pflip);
      bit b, rdy, clr, st;
      for (int k = 0; k < nbits; k++) begin
         rdy = (rmode == 2) ? bit'($urandom_range(1)) : (rmode == 1);
         clr = (rmode == 2) ? ($urandom_range(7) == 0) : 1'b0;
         for (int g = 0; g < gap; g++)
            cycle(0, bit'($urandom_range(1)), bit'($urandom_range(1)),
                  bit'($urandom_range(1)), rdy, clr);
         if (k < W) b = dir ? w[k] : w[W-1-k];
         else       b = (^w) ^ pflip;
         st = (k == 0) || (rmode == 2 && $urandom_range(15) == 0);
         cycle(1, st, b, dir, rdy, clr);
      end
   endtask

   task automatic async_reset();
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      compare_all();
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; serial_i = 0; bit_valid_i = 0; start_i = 0; dir_i = 0;
      ready_i = 0; clr_ovr_i = 0;
      model_reset();
      #1;
      compare_all();
      @(posedge clk);
      #1;
      rst = 1'b0;

      // MSB-first B2, one bit per cycle, consumer ready
      send_bits(8'hB2, 0, FRAME, 0, 1, 0);
      check("msb_word", 32'(word_o), 32'hB2);
      check("msb_valid", 32'(valid_o), 32'd1);
      cycle(0, 0, 0, 0, 1, 0);
      check("msb_valid_drop", 32'(valid_o), 32'd0);

      // LSB-first B2 with 3-cycle gaps
      send_bits(8'hB2, 1, FRAME, 3, 1, 0);
      check("lsb_word", 32'(word_o), 32'hB2);
      cycle(0, 0, 0, 0, 1, 0);

      // back-to-back frames into a stalled consumer
      send_bits(8'h5A, 0, FRAME, 0, 0, 0);
      send_bits(8'hC3, 0, FRAME, 0, 0, 0);
      check("ovr_word_held", 32'(word_o), 32'h5A);
      check("ovr_set", 32'(overrun_o), 32'd1);
      cycle(0, 0, 0, 0, 1, 0);
      check("ovr_consume", 32'(valid_o), 32'd0);
      cycle(0, 0, 0, 0, 0, 1);
      check("ovr_clear", 32'(overrun_o), 32'd0);

      // resync: 4 bits, then start reasserted on bit 5 with a full FF frame
      send_bits(8'h96, 0, 4, 0, 1, 0);
      send_bits(8'hFF, 0, FRAME, 0, 1, 0);
      check("resync_word", 32'(word_o), 32'hFF);
      check("resync_ovr", 32'(overrun_o), 32'd0);
      cycle(0, 0, 0, 0, 1, 0);

      // asynchronous reset mid-frame and with a word pending
      send_bits(8'hA5, 0, 4, 0, 1, 0);
      async_reset();
      send_bits(8'h01, 0, FRAME, 0, 0, 0);
      async_reset();
      send_bits(8'h01, 0, FRAME, 0, 1, 0);
      check("post_rst_word", 32'(word_o), 32'h01);
      cycle(0, 0, 0, 0, 1, 0);

`ifdef SHIFT_DESERIALIZER_PARITY_EN
      send_bits(8'h03, 0, FRAME, 0, 1, 0);
      check("par_ok", 32'(parity_err_o), 32'd0);
      send_bits(8'h03, 0, FRAME, 0, 1, 1);
      check("par_bad", 32'(parity_err_o), 32'd1);
      check("par_bad_valid", 32'(valid_o), 32'd1);
      check("par_bad_word", 32'(word_o), 32'h03);
      cycle(0, 0, 0, 0, 1, 0);
      check("par_clear", 32'(parity_err_o), 32'd0);
`endif

      // randomized frames: random data, direction, gaps, ready, clears, glitches
      for (int f = 0; f < 60; f++) begin
         send_bits(W'($urandom), bit'($urandom_range(1)), FRAME, $urandom_range(2), 2,
                   bit'($urandom_range(1)));
      end
      for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 1, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/shift_deserializer.md
Name: shift_deserializer

Overview:
- Receive-side counterpart of the team's shift-register-with-parallel-load transmitter.
- That transmitter parallel-loads a word and shifts it out one bit per enabled clock, either left (MSB first) or right (LSB first).
- This block samples the serial stream, rebuilds the word in an internal shift register and presents it through a one-entry output buffer with a valid/ready handshake.
- It sits between a serial link and a parallel consumer; word N+1 can be assembled while word N waits in the buffer.

Parameters:
WIDTH, 8, data word width in bits (>= 2)

Ports:
clk  input  1  system clock; all sampling on rising edge
rst  input  1  asynchronous, active-high reset
serial_i  input  1  serial data bit
bit_valid_i  input  1  serial_i holds a valid bit this cycle
start_i  input  1  first bit of a word; qualified by bit_valid_i
dir_i  input  1  0 = MSB first (shift left, new bit enters bit 0); 1 = LSB first (shift right, new bit enters bit WIDTH-1); sampled with start bit only
ready_i  input  1  consumer accepts word_o this cycle
clr_ovr_i  input  1  clears overrun_o
word_o  output  WIDTH  received word
valid_o  output  1  word_o holds an unconsumed word
busy_o  output  1  a word is being assembled (state SHIFT)
overrun_o  output  1  sticky: a completed word was dropped
parity_err_o  output  1  parity error on word in buffer (see Optional Feature)

Behaviour:
- Reset (asynchronous, any state or mid-word): state = IDLE; shift register = 0; bit count = 0; word_o = 0; valid_o = 0; busy_o = 0; overrun_o = 0; parity_err_o = 0.
- States: IDLE, SHIFT.
- IDLE:
  - bit_valid_i=1 and start_i=1: latch dir_i, shift in serial_i, count = 1, go to SHIFT.
  - bit_valid_i=1 and start_i=0: bit ignored.
- SHIFT, bit_valid_i=1 and start_i=0: shift in serial_i, count += 1.
  - When this bit is the last data bit (count was WIDTH-1), the word completes: go to IDLE, count = 0.
- SHIFT, bit_valid_i=1 and start_i=1: resynchronise. Discard the partial word, re-latch dir_i, treat the bit as bit 1 (count = 1), stay in SHIFT. No error flag.
- SHIFT, bit_valid_i=0: hold everything. Gaps of any length are legal.
- Word completion and buffer:
  - word_o and valid_o update on the clock edge that samples the final bit, so they are visible the cycle after that bit is presented (latency 1).
  - Buffer empty, or valid_o=1 with ready_i=1 in the same cycle: load word_o, valid_o = 1. Back-to-back handoff, no overrun.
  - valid_o=1 and ready_i=0: completed word dropped; word_o unchanged; overrun_o set to 1.
- Handshake:
  - Transfer occurs when valid_o=1 and ready_i=1; valid_o clears the next cycle unless a new word loads in the same cycle.
  - word_o must stay stable while valid_o=1 and ready_i=0.
  - ready_i is ignored when valid_o=0.
- overrun_o:
  - Sticky; cleared only by clr_ovr_i or rst.
  - If clr_ovr_i=1 coincides with a new overrun event, set wins (overrun_o = 1).
- busy_o = 1 exactly while state = SHIFT.
- Bit ordering: with matching dir settings, a word shifted out by the transmitter is reproduced bit-exact in word_o.

Optional Feature:
- Macro: SHIFT_DESERIALIZER_PARITY_EN.
- Defined:
  - Each frame carries WIDTH data bits followed by one even-parity bit (XOR of data bits and parity bit = 0).
  - Word completion occurs on the parity bit, not the last data bit; the parity bit is not stored in word_o.
  - parity_err_o loads together with word_o, holds that word's error status, and clears when the word is consumed with no new load.
  - Overrun rules are unchanged.
- Undefined: frames are exactly WIDTH bits; parity_err_o is tied to 0.

Test Plan:
- Reset then MSB-first frame, dir_i=0, bits 1,0,1,1,0,0,1,0, one bit per cycle, ready_i=1 -> word_o=8'hB2, valid_o=1 one cycle after the 8th bit, then 0 next cycle; busy_o high for 7 cycles.
- LSB-first frame, dir_i=1, bits 0,1,0,0,1,1,0,1 with 3-cycle bit_valid_i gaps -> word_o=8'hB2; no change to state or count during the gaps.
- Two back-to-back frames (8'h5A, then 8'hC3), ready_i=0 until after the second completes -> word_o=8'h5A held, overrun_o=1. Then ready_i=1 -> valid_o drops. Then clr_ovr_i=1 -> overrun_o=0.
- start_i reasserted at bit 5 of a partial frame, followed by a full frame 8'hFF -> word_o=8'hFF, single valid pulse, overrun_o=0.
- rst asserted mid-frame (after 4 bits) and while valid_o=1 -> all outputs 0 immediately, without waiting for a clock edge. A following full frame 8'h01 -> word_o=8'h01.
- With SHIFT_DESERIALIZER_PARITY_EN: frame 8'h03 plus parity 0 -> parity_err_o=0. Frame 8'h03 plus parity 1 -> parity_err_o=1 alongside valid_o, word_o=8'h03.
